// File: rtl/wide_alu_pkg.sv
// ---------------------------------------------------------------------------
// wide_alu_pkg
// Shared types and constants for the 64-bit two-pass ALU controller:
//   - op_e      : request opcode (ADD/SUB/AND/ORR)
//   - state_e   : controller FSM states (IDLE/LO/HI/DONE)
//   - ALU_*     : 3-bit control codes understood by the 32-bit alu
//   - FLAG_*    : bit positions inside a {N,Z,C,V} flag vector
//   - hi_ctrl() : maps an opcode to the control code used on the upper half
// ---------------------------------------------------------------------------
package wide_alu_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_ORR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_ADC = 3'b100;
  localparam logic [2:0] ALU_SBC = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Upper half of an arithmetic op must chain the lower-half carry, so
  // ADD/SUB become ADC/SBC; logic ops have no carry chain.
  function automatic logic [2:0] hi_ctrl(input op_e op);
    if (op == OP_ADD || op == OP_SUB) begin
      return {1'b1, op};
    end
    return {1'b0, op};
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational 32-bit ALU with ARM-style flags.
// Ports:
//   src_a, src_b  in  32  operands
//   alu_control   in  3   000 ADD, 001 SUB, 010 AND, 011 ORR, 100 ADC, 101 SBC
//   carry         in  1   carry input, consumed only by ADC/SBC
//   result        out 32  operation result
//   flags         out 4   {N,Z,C,V}; C/V are 0 for logic ops
// SUB/SBC are computed as a + ~b + cin, so C=1 means "no borrow".
// ---------------------------------------------------------------------------
module alu
  import wide_alu_pkg::*;
(
  input  logic [HALF_W-1:0] src_a,
  input  logic [HALF_W-1:0] src_b,
  input  logic [2:0]        alu_control,
  input  logic              carry,
  output logic [HALF_W-1:0] result,
  output logic [3:0]        flags
);

  logic [HALF_W-1:0] b_eff;
  logic              cin;
  logic              is_arith;
  logic [HALF_W:0]   sum;
  logic              ovf;

  always_comb begin
    b_eff    = src_b;
    cin      = 1'b0;
    is_arith = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        is_arith = 1'b1;
      end
      ALU_SUB: begin
        is_arith = 1'b1;
        b_eff    = ~src_b;
        cin      = 1'b1;
      end
      ALU_ADC: begin
        is_arith = 1'b1;
        cin      = carry;
      end
      ALU_SBC: begin
        is_arith = 1'b1;
        b_eff    = ~src_b;
        cin      = carry;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, src_a} + {1'b0, b_eff} + {{HALF_W{1'b0}}, cin};

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBC: result = sum[HALF_W-1:0];
      ALU_AND:                            result = src_a & src_b;
      ALU_ORR:                            result = src_a | src_b;
      default:                            result = '0;
    endcase
  end

  // Signed overflow: both addends share a sign that the sum does not.
  assign ovf = (src_a[HALF_W-1] == b_eff[HALF_W-1]) &&
               (result[HALF_W-1] != src_a[HALF_W-1]);

  assign flags = {result[HALF_W-1],
                  (result == '0),
                  is_arith & sum[HALF_W],
                  is_arith & ovf};

endmodule

// File: rtl/wide_alu_ctrl.sv
// ---------------------------------------------------------------------------
// wide_alu_ctrl
// 64-bit ADD/SUB/AND/ORR built from one shared 32-bit alu used twice:
// the LO cycle computes the lower half, the HI cycle the upper half with the
// lower-half carry chained in. Ready/valid handshake on both sides.
// Ports:
//   clk          in  1   clock, rising edge
//   reset        in  1   asynchronous active-high reset
//   req_valid    in  1   request present
//   req_ready    out 1   high only in IDLE
//   req_op       in  2   00 ADD, 01 SUB, 10 AND, 11 ORR
//   req_a, req_b in  64  operands, captured on acceptance
//   rsp_valid    out 1   high only in DONE
//   rsp_ready    in  1   consumer accepts the result
//   rsp_result   out 64  result, held stable while rsp_valid && !rsp_ready
//   rsp_flags    out 4   {N,Z,C,V} of the 64-bit operation
// Timing: accept in IDLE, LO, HI, then rsp_valid in DONE (3 cycles after the
// accepting edge); back-to-back initiation interval is 4 cycles.
// ---------------------------------------------------------------------------
module wide_alu_ctrl
  import wide_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags
);

  state_e            state;
  op_e               op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [HALF_W-1:0] res_lo;
  logic              z_lo;
  logic              c_lo;

  logic [HALF_W-1:0] alu_src_a;
  logic [HALF_W-1:0] alu_src_b;
  logic [2:0]        alu_ctrl;
  logic [HALF_W-1:0] alu_result;
  logic [3:0]        alu_flags;

  // ALU inputs are parked at zero outside LO/HI.
  always_comb begin
    alu_src_a = '0;
    alu_src_b = '0;
    alu_ctrl  = ALU_ADD;
    case (state)
      ST_LO: begin
        alu_src_a = a_q[HALF_W-1:0];
        alu_src_b = b_q[HALF_W-1:0];
        alu_ctrl  = {1'b0, op_q};
      end
      ST_HI: begin
        alu_src_a = a_q[DATA_W-1:HALF_W];
        alu_src_b = b_q[DATA_W-1:HALF_W];
        alu_ctrl  = hi_ctrl(op_q);
      end
      default: ;
    endcase
  end

  alu u_alu (
    .src_a       (alu_src_a),
    .src_b       (alu_src_b),
    .alu_control (alu_ctrl),
    .carry       (c_lo),
    .result      (alu_result),
    .flags       (alu_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      res_lo     <= '0;
      z_lo       <= 1'b0;
      c_lo       <= 1'b0;
    end else begin
      case (state)
        // IDLE: capture the request so later input changes cannot leak in
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= op_e'(req_op);
            a_q       <= req_a;
            b_q       <= req_b;
            req_ready <= 1'b0;
            state     <= ST_LO;
          end
        end
        // LO: lower half result, keep Z for the 64-bit Z and C for the chain
        ST_LO: begin
          res_lo <= alu_result;
          z_lo   <= alu_flags[FLAG_Z];
          c_lo   <= alu_flags[FLAG_C];
          state  <= ST_HI;
        end
        // HI: upper half; N/C/V come from the top half, Z spans both halves
        ST_HI: begin
          rsp_result <= {alu_result, res_lo};
          rsp_flags  <= {alu_flags[FLAG_N],
                         z_lo & alu_flags[FLAG_Z],
                         alu_flags[FLAG_C],
                         alu_flags[FLAG_V]};
          rsp_valid  <= 1'b1;
          state      <= ST_DONE;
        end
        // DONE: hold the response until the consumer takes it
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wide_alu_ctrl
// Self-checking bench for wide_alu_ctrl. Expected results come from an
// independent 64-bit reference model, queued when a request is issued and
// popped when the response appears.
// ---------------------------------------------------------------------------
module tb_wide_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  wide_alu_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t        e;
    logic [64:0] s;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      2'b00: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[63:0];
        c     = s[64];
        v     = (a[63] == b[63]) && (e.res[63] != a[63]);
      end
      2'b01: begin
        s     = {1'b0, a} + {1'b0, ~b} + 65'd1;
        e.res = s[63:0];
        c     = s[64];
        v     = (a[63] != b[63]) && (e.res[63] != a[63]);
      end
      2'b10:   e.res = a & b;
      default: e.res = a | b;
    endcase
    e.fl = {e.res[63], (e.res == 64'd0), c, v};
    return e;
  endfunction

  // Issue one request, scramble the operand inputs right after acceptance,
  // and return once rsp_valid is seen (rsp_ready stays low: DUT left in DONE).
  task automatic run_op(input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, output exp_t got, output int lat);
    int w;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    sb.push_back(model(op, a, b));
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = ~op;
    req_a     = ~a;
    req_b     = ~b ^ 64'h5A5A_5A5A_5A5A_5A5A;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = {rsp_result, rsp_flags};
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 64'd0 || rsp_flags !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b res=%h fl=%b want 0/0/0",
               rsp_valid, rsp_result, rsp_flags);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_add_carry();
    exp_t got, e;
    int   lat;
    run_op(2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1, got, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL add_latency got %0d want 3", lat);
    end
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL add_carry got %h/%b want %h/%b", got.res, got.fl, e.res, e.fl);
    end
    release_rsp();
  endtask

  task automatic test_sub();
    exp_t got, e;
    int   lat;
    run_op(2'b01, 64'd0, 64'd1, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e || lat !== 3) begin
      errors++;
      $display("FAIL sub_borrow got %h/%b lat %0d want %h/%b lat 3",
               got.res, got.fl, lat, e.res, e.fl);
    end
    release_rsp();
    run_op(2'b01, 64'd5, 64'd5, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL sub_equal got %h/%b want %h/%b", got.res, got.fl, e.res, e.fl);
    end
    release_rsp();
  endtask

  task automatic test_overflow_and();
    exp_t got, e;
    int   lat;
    run_op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL add_overflow got %h/%b want %h/%b", got.res, got.fl, e.res, e.fl);
    end
    release_rsp();
    run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL and_zero got %h/%b want %h/%b", got.res, got.fl, e.res, e.fl);
    end
    release_rsp();
    run_op(2'b11, 64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL orr_neg got %h/%b want %h/%b", got.res, got.fl, e.res, e.fl);
    end
    release_rsp();
  endtask

  task automatic test_backpressure();
    exp_t got, e;
    int   lat;
    bit   bad;
    run_op(2'b01, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL bp_result got %h/%b want %h/%b", got.res, got.fl, e.res, e.fl);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2);
      req_op    = 2'b11;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          {rsp_result, rsp_flags} !== e) bad = 1'b1;
    end
    req_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold got %h/%b valid=%b ready=%b want %h/%b 1/0",
               rsp_result, rsp_flags, rsp_valid, req_ready, e.res, e.fl);
    end
    release_rsp();
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy_pulse_ignored got valid=%b ready=%b want 0/1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t got, e;
    int   lat;
    bit   bad;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_a     = 64'hAAAA_AAAA_AAAA_AAAA;
    req_b     = 64'h1111_1111_1111_1111;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got %b want 0", req_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
        rsp_result !== 64'd0 || rsp_flags !== 4'd0) begin
      errors++;
      $display("FAIL async_reset got valid=%b ready=%b res=%h fl=%b want 0/1/0/0",
               rsp_valid, req_ready, rsp_result, rsp_flags);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL aborted_no_rsp got rsp_valid=1 want 0");
    end
    run_op(2'b00, 64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e || lat !== 3) begin
      errors++;
      $display("FAIL post_reset_op got %h/%b lat %0d want %h/%b lat 3",
               got.res, got.fl, lat, e.res, e.fl);
    end
    release_rsp();
  endtask

  task automatic test_operand_change();
    exp_t got, e;
    int   lat;
    run_op(2'b00, 64'h0F0F_0F0F_F0F0_F0F0, 64'h0101_0101_1010_1010, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL operand_latch got %h/%b want %h/%b", got.res, got.fl, e.res, e.fl);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    exp_t        got, e;
    int          lat;
    logic [1:0]  op;
    logic [63:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = (i % 3 == 0) ? a : {$urandom, $urandom};
      run_op(op, a, b, got, lat);
      e = sb.pop_front();
      checks++;
      if (got !== e || lat !== 3) begin
        errors++;
        $display("FAIL b2b_%0d op %0d got %h/%b lat %0d want %h/%b lat 3",
                 i, op, got.res, got.fl, lat, e.res, e.fl);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ii_%0d got ready=%b valid=%b want 1/0",
                 i, req_ready, rsp_valid);
      end
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_overflow_and();
    test_backpressure();
    test_reset_mid_op();
    test_operand_change();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/wide_alu_ctrl.md
WIDE_ALU_CTRL -- requirements
Module: wide_alu_ctrl

Interface
REQ-001 Parameters: none; the data width is fixed at 64 bits, built as two 32-bit halves.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_op  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-007 req_a, req_b  input  64  operands.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_result  output  64  64-bit result.
REQ-011 rsp_flags  output  4  {N,Z,C,V} of the 64-bit operation.

Function
REQ-012 The FSM SHALL have four states: IDLE, LO, HI, DONE.
REQ-013 IDLE: req_ready=1; on req_valid&req_ready, latch req_op/req_a/req_b and go to LO.
REQ-014 LO: drive ALU with SrcA=a[31:0], SrcB=b[31:0], ALUControl={1'b0,op}; latch the result into res_lo, its Z flag into z_lo, its C flag into c_lo; go to HI.
REQ-015 HI: drive SrcA=a[63:32], SrcB=b[63:32], carry=c_lo; ALUControl={1'b1,op} for ADD/SUB (ADC/SBC) and {1'b0,op} for AND/ORR.
REQ-016 HI: latch rsp_result={hi_result,res_lo} and rsp_flags={N_hi, z_lo&Z_hi, C_hi, V_hi}; go to DONE.
REQ-017 DONE: rsp_valid=1; on rsp_ready go to IDLE; otherwise hold rsp_result and rsp_flags stable.
REQ-018 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in DONE.
REQ-019 Latency: rsp_valid rises 3 cycles after the accepting edge; minimum initiation interval is 4 cycles.
REQ-020 SUB carry uses ARM convention: C=1 means no borrow.
REQ-021 AND/ORR SHALL produce C=0, V=0, with N and Z from the 64-bit result.
REQ-022 Operand inputs changing after acceptance SHALL NOT affect the result.
REQ-023 req_valid in non-IDLE states is ignored, not queued.
REQ-024 ALU control and operand signals SHALL be zero in IDLE and DONE.

Reset
REQ-025 reset SHALL force IDLE asynchronously, from any state including LO/HI mid-operation.
REQ-026 Reset values: rsp_result=0, rsp_flags=0, rsp_valid=0, req_ready=1 after release, latched operands, res_lo, z_lo and c_lo=0.
REQ-027 A request aborted by reset SHALL produce no response.

Structure
REQ-028 Package wide_alu_pkg SHALL hold the op enum, the FSM state enum, and the ALUControl constants (ADD=000, SUB=001, AND=010, ORR=011, ADC=100, SBC=101).
REQ-029 The block SHALL instantiate exactly one sub-module: the existing 32-bit alu, shared across the LO and HI cycles.
REQ-030 The ALU carry input SHALL be tied to c_lo; c_lo is used only when ALUControl[2]=1.

Verification
REQ-031 ADD a=0x00000000_FFFFFFFF, b=1 -> result 0x00000001_00000000, flags 0000, rsp_valid 3 cycles after accept.
REQ-032 SUB a=0, b=1 -> 0xFFFFFFFF_FFFFFFFF, flags 1000; SUB a=5, b=5 -> 0, flags 0110.
REQ-033 ADD a=0x7FFFFFFF_FFFFFFFF, b=1 -> 0x80000000_00000000, flags 1001; AND a=all-ones, b=0 -> 0, flags 0100.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in DONE -> result/flags stable, req_ready=0; while busy, a req_valid pulse is ignored.
REQ-035 Reset asserted during HI -> immediate IDLE, outputs 0; the next request completes correctly.
REQ-036 Operands changed the cycle after accept -> result reflects the latched values.
